// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy controller front end (conditioner and fuzzifier).
package fuzzy_pkg;

    localparam int unsigned ADC_W  = 12;
    localparam int unsigned ERR_W  = 13;
    localparam int unsigned DERR_W = 14;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        COMPUTE = 2'd1,
        PUBLISH = 2'd2
    } cond_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: registered one-cycle tick every SAMPLE_DIV clocks while enabled.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
    localparam int unsigned LAST  = SAMPLE_DIV - 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // tick_q is high exactly while count_q sits at its terminal value
    always_comb begin
        count_d = '0;
        tick_d  = 1'b0;
        if (enable) begin
            if (count_q == CNT_W'(LAST)) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            tick_d = (count_d == CNT_W'(LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/fuzzy_input_conditioner.sv
// Windowed averaging of the v1/v2 ADC pair into signed err/derr crisp inputs for the fuzzifier.
module fuzzy_input_conditioner
    import fuzzy_pkg::*;
#(
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned SAMPLE_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADC_W-1:0]  v1,
    input  logic [ADC_W-1:0]  v2,
    output logic [ERR_W-1:0]  err,
    output logic [DERR_W-1:0] derr,
    output logic              out_valid,
    output logic              first
);

    localparam int unsigned ACC_W    = ADC_W + AVG_LOG2;
    localparam int unsigned N_W      = AVG_LOG2 + 1;
    localparam int unsigned WIN_LAST = (1 << AVG_LOG2) - 1;

    logic tick;

    cond_state_t       state_q, state_d;
    logic [ACC_W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [ERR_W-1:0]  err_q, err_d, err_prev_q, err_prev_d;
    logic [DERR_W-1:0] derr_q, derr_d;
    logic              first_q, first_d;
    logic              first_pending_q, first_pending_d;
    logic              out_valid_q, out_valid_d;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Disable has priority: abandon the partial window and restart the first-result flag
    always_comb begin
        state_d         = state_q;
        acc1_d          = acc1_q;
        acc2_d          = acc2_q;
        n_d             = n_q;
        err_d           = err_q;
        derr_d          = derr_q;
        err_prev_d      = err_prev_q;
        first_d         = first_q;
        first_pending_d = first_pending_q;
        out_valid_d     = 1'b0;

        if (!enable) begin
            state_d         = ACC;
            acc1_d          = '0;
            acc2_d          = '0;
            n_d             = '0;
            first_pending_d = 1'b1;
        end else begin
            case (state_q)
                ACC: begin
                    if (tick) begin
                        acc1_d = acc1_q + ACC_W'(v1);
                        acc2_d = acc2_q + ACC_W'(v2);
                        n_d    = n_q + N_W'(1);
                        if (n_q == N_W'(WIN_LAST)) begin
                            state_d = COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    err_d   = ERR_W'(acc1_q >> AVG_LOG2) - ERR_W'(acc2_q >> AVG_LOG2);
                    acc1_d  = '0;
                    acc2_d  = '0;
                    n_d     = '0;
                    state_d = PUBLISH;
                end
                PUBLISH: begin
                    if (first_pending_q) begin
                        derr_d = '0;
                    end else begin
                        derr_d = {err_q[ERR_W-1], err_q} - {err_prev_q[ERR_W-1], err_prev_q};
                    end
                    err_prev_d      = err_q;
                    first_d         = first_pending_q;
                    first_pending_d = 1'b0;
                    out_valid_d     = 1'b1;
                    state_d         = ACC;
                end
                default: begin
                    state_d = ACC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ACC;
            acc1_q          <= '0;
            acc2_q          <= '0;
            n_q             <= '0;
            err_q           <= '0;
            derr_q          <= '0;
            err_prev_q      <= '0;
            first_q         <= 1'b0;
            first_pending_q <= 1'b1;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc1_q          <= acc1_d;
            acc2_q          <= acc2_d;
            n_q             <= n_d;
            err_q           <= err_d;
            derr_q          <= derr_d;
            err_prev_q      <= err_prev_d;
            first_q         <= first_d;
            first_pending_q <= first_pending_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign err       = err_q;
    assign derr      = derr_q;
    assign out_valid = out_valid_q;
    assign first     = first_q;

endmodule
